// File: rtl/mai_rd_arbiter.sv
// Read-path arbiter between the IF and DM masters and the MAC: QoS/round-robin request
// grant into a single output slot, with in-order response routing driven by a source-tracking FIFO.
module mai_rd_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       iIF_ValidRd,
    input  logic [31:0]                iIF_AddrRd,
    input  logic [3:0]                 iIF_TagRd,
    input  logic [2:0]                 iIF_IdRd,
    input  logic [1:0]                 iIF_LenRd,
    input  logic [3:0]                 iIF_QoSRd,
    output logic                       oIF_ReadyRd,

    input  logic                       iDM_ValidRd,
    input  logic [31:0]                iDM_AddrRd,
    input  logic [3:0]                 iDM_TagRd,
    input  logic [2:0]                 iDM_IdRd,
    input  logic [1:0]                 iDM_LenRd,
    input  logic [3:0]                 iDM_QoSRd,
    output logic                       oDM_ReadyRd,

    output logic                       oMAC_ValidRd,
    output logic [31:0]                oMAC_AddrRd,
    output logic [3:0]                 oMAC_TagRd,
    output logic [2:0]                 oMAC_IdRd,
    output logic [1:0]                 oMAC_LenRd,
    output logic [3:0]                 oMAC_QoSRd,
    input  logic                       iMAC_ReadyRd,

    input  logic                       iMAC_ValidRsp,
    input  logic [3:0]                 iMAC_TagRsp,
    input  logic [31:0]                iMAC_DataRsp,
    input  logic [1:0]                 iMAC_StatusRsp,
    input  logic                       iMAC_EoD,
    output logic                       oMAC_ReadyRsp,

    output logic                       oIF_ValidRsp,
    output logic [3:0]                 oIF_TagRsp,
    output logic [31:0]                oIF_DataRsp,
    output logic [1:0]                 oIF_StatusRsp,
    output logic                       oIF_EoD,
    input  logic                       iIF_ReadyRsp,

    output logic                       oDM_ValidRsp,
    output logic [3:0]                 oDM_TagRsp,
    output logic [31:0]                oDM_DataRsp,
    output logic [1:0]                 oDM_StatusRsp,
    output logic                       oDM_EoD,
    input  logic                       iDM_ReadyRsp,

    output logic [$clog2(DEPTH):0]     oOutstanding,
    output logic                       oErrOrphan,
    output logic                       oErrLen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Request slot
    logic          slotValidReg;
    logic [31:0]   slotAddrReg;
    logic [3:0]    slotTagReg;
    logic [2:0]    slotIdReg;
    logic [1:0]    slotLenReg;
    logic [3:0]    slotQoSReg;

    // Set when DM was the last master granted; an equal-QoS tie goes to the other one
    logic          rrLastDmReg;

    // Tracking FIFO: source (0 = IF, 1 = DM) and burst length per outstanding request
    logic          srcMem [DEPTH];
    logic [1:0]    lenMem [DEPTH];
    logic [AW-1:0] wrPtrReg;
    logic [AW-1:0] rdPtrReg;
    logic [CW-1:0] countReg;

    // Beat index within the current burst; saturates at 4 to act as the overflow flag
    logic [2:0]    beatIdxReg;
    logic [2:0]    beatIdxNext;

    logic          errOrphanReg;
    logic          errLenReg;

    logic          slotFree;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          grantIf;
    logic          grantDm;
    logic          acceptIf;
    logic          acceptDm;
    logic          push;
    logic          pop;
    logic          headSrc;
    logic [1:0]    headLen;
    logic          beatAccept;
    logic          lenMismatch;

    logic [31:0]   reqAddr;
    logic [3:0]    reqTag;
    logic [2:0]    reqId;
    logic [1:0]    reqLen;
    logic [3:0]    reqQoS;

    assign slotFree  = !slotValidReg || iMAC_ReadyRd;
    assign fifoFull  = (countReg == CW'(DEPTH));
    assign fifoEmpty = (countReg == '0);

    always_comb begin
        grantIf = 1'b0;
        grantDm = 1'b0;
        if (iIF_ValidRd && iDM_ValidRd) begin
            if (iIF_QoSRd > iDM_QoSRd) begin
                grantIf = 1'b1;
            end else if (iDM_QoSRd > iIF_QoSRd) begin
                grantDm = 1'b1;
            end else if (rrLastDmReg) begin
                grantIf = 1'b1;
            end else begin
                grantDm = 1'b1;
            end
        end else begin
            grantIf = iIF_ValidRd;
            grantDm = iDM_ValidRd;
        end
    end

    // A full FIFO blocks the grant even when a pop happens in the same cycle
    assign oIF_ReadyRd = grantIf && slotFree && !fifoFull && !reset;
    assign oDM_ReadyRd = grantDm && slotFree && !fifoFull && !reset;
    assign acceptIf    = oIF_ReadyRd && iIF_ValidRd;
    assign acceptDm    = oDM_ReadyRd && iDM_ValidRd;
    assign push        = acceptIf || acceptDm;

    always_comb begin
        reqAddr = iIF_AddrRd;
        reqTag  = iIF_TagRd;
        reqId   = iIF_IdRd;
        reqLen  = iIF_LenRd;
        reqQoS  = iIF_QoSRd;
        if (acceptDm) begin
            reqAddr = iDM_AddrRd;
            reqTag  = iDM_TagRd;
            reqId   = iDM_IdRd;
            reqLen  = iDM_LenRd;
            reqQoS  = iDM_QoSRd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slotValidReg <= 1'b0;
            slotAddrReg  <= '0;
            slotTagReg   <= '0;
            slotIdReg    <= '0;
            slotLenReg   <= '0;
            slotQoSReg   <= '0;
            rrLastDmReg  <= 1'b1;
        end else if (push) begin
            slotValidReg <= 1'b1;
            slotAddrReg  <= reqAddr;
            slotTagReg   <= reqTag;
            slotIdReg    <= reqId;
            slotLenReg   <= reqLen;
            slotQoSReg   <= reqQoS;
            rrLastDmReg  <= acceptDm;
        end else if (iMAC_ReadyRd) begin
            slotValidReg <= 1'b0;
        end
    end

    assign oMAC_ValidRd = slotValidReg;
    assign oMAC_AddrRd  = slotAddrReg;
    assign oMAC_TagRd   = slotTagReg;
    assign oMAC_IdRd    = slotIdReg;
    assign oMAC_LenRd   = slotLenReg;
    assign oMAC_QoSRd   = slotQoSReg;

    always_ff @(posedge clk) begin
        if (push) begin
            srcMem[wrPtrReg] <= acceptDm;
            lenMem[wrPtrReg] <= reqLen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (push) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (pop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
            case ({push, pop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    assign headSrc = srcMem[rdPtrReg];
    assign headLen = lenMem[rdPtrReg];

    // Response routing is purely combinational; with nothing outstanding every beat is sunk
    assign oIF_ValidRsp  = !fifoEmpty && !headSrc && iMAC_ValidRsp;
    assign oDM_ValidRsp  = !fifoEmpty &&  headSrc && iMAC_ValidRsp;
    assign oMAC_ReadyRsp = fifoEmpty || (headSrc ? iDM_ReadyRsp : iIF_ReadyRsp);

    assign oIF_TagRsp    = iMAC_TagRsp;
    assign oIF_DataRsp   = iMAC_DataRsp;
    assign oIF_StatusRsp = iMAC_StatusRsp;
    assign oIF_EoD       = iMAC_EoD;
    assign oDM_TagRsp    = iMAC_TagRsp;
    assign oDM_DataRsp   = iMAC_DataRsp;
    assign oDM_StatusRsp = iMAC_StatusRsp;
    assign oDM_EoD       = iMAC_EoD;

    assign beatAccept  = iMAC_ValidRsp && oMAC_ReadyRsp && !fifoEmpty;
    assign pop         = beatAccept && iMAC_EoD;
    assign lenMismatch = beatAccept &&
                         (iMAC_EoD ? (beatIdxReg != {1'b0, headLen})
                                   : (beatIdxReg >  {1'b0, headLen}));

    always_comb begin
        beatIdxNext = beatIdxReg;
        if (beatAccept) begin
            if (iMAC_EoD) begin
                beatIdxNext = 3'd0;
            end else if (beatIdxReg != 3'd4) begin
                beatIdxNext = beatIdxReg + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beatIdxReg   <= '0;
            errOrphanReg <= 1'b0;
            errLenReg    <= 1'b0;
        end else begin
            beatIdxReg <= beatIdxNext;
            if (iMAC_ValidRsp && fifoEmpty) begin
                errOrphanReg <= 1'b1;
            end
            if (lenMismatch) begin
                errLenReg <= 1'b1;
            end
        end
    end

    assign oOutstanding = countReg;
    assign oErrOrphan   = errOrphanReg;
    assign oErrLen      = errLenReg;

endmodule

// File: doc/mai_rd_arbiter.md
# mai_rd_arbiter

Read-path arbitration and response-routing stage between the two memory-access masters (IF, DM) and the Memory Access Controller (MAC). It selects one read request per cycle by QoS, with round-robin on ties, and registers it toward the MAC. It records the source and burst length of every accepted request in an in-order tracking FIFO. It steers the MAC's in-order response beats back to the issuing master and checks each burst's beat count.

## Interface
Parameters:
- DEPTH, 4, outstanding-request FIFO depth; power of 2, minimum 2.

Ports (X = IF and DM; each X port exists once per master):
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- iX_ValidRd  in  1  read request valid from master X.
- iX_AddrRd / iX_TagRd / iX_IdRd / iX_LenRd / iX_QoSRd  in  32/4/3/2/4  request fields. Len = beats-1. Higher QoS value = higher priority.
- oX_ReadyRd  out  1  request accepted when high with iX_ValidRd.
- oMAC_ValidRd  out  1  registered request valid to MAC.
- oMAC_AddrRd / oMAC_TagRd / oMAC_IdRd / oMAC_LenRd / oMAC_QoSRd  out  32/4/3/2/4  registered request fields.
- iMAC_ReadyRd  in  1  MAC accepts request.
- iMAC_ValidRsp / iMAC_TagRsp / iMAC_DataRsp / iMAC_StatusRsp / iMAC_EoD  in  1/4/32/2/1  response beat from MAC; EoD marks the last beat.
- oMAC_ReadyRsp  out  1  response beat accepted.
- oX_ValidRsp / oX_TagRsp / oX_DataRsp / oX_StatusRsp / oX_EoD  out  1/4/32/2/1  routed response to master X.
- iX_ReadyRsp  in  1  master X accepts response beat.
- oOutstanding  out  log2(DEPTH)+1  FIFO occupancy.
- oErrOrphan  out  1  sticky: MAC response beat while FIFO empty.
- oErrLen  out  1  sticky: burst beat count differs from Len+1.

## Operation
- Request slot: one output register. `slot_free = !oMAC_ValidRd || iMAC_ReadyRd`.
- Grant is combinational over the valid requesters:
  - Higher QoS wins.
  - Equal QoS: the master not granted last wins (rr pointer).
- Ready to the granted master: `oX_ReadyRd = grant_X && slot_free && !fifo_full`. The non-granted master's ready is 0.
- On accept:
  - Load the request fields into the slot and set oMAC_ValidRd.
  - Push {src, Len} into the FIFO.
  - Update the rr pointer to the granted master.
- Slot handoff: if MAC accepts and no new grant occurs, oMAC_ValidRd clears. Slot fields hold while oMAC_ValidRd=1 and iMAC_ReadyRd=0.
- Full FIFO blocks grants even if a pop occurs in the same cycle. There is no same-cycle push-through-full.
- Response routing is combinational from the FIFO head (src, len) when the FIFO is non-empty:
  - oSRC_ValidRsp = iMAC_ValidRsp.
  - Data, Tag, Status and EoD are forwarded; the other master's ValidRsp is 0.
  - oMAC_ReadyRsp = iSRC_ReadyRsp.
- Beat counter (2 bits + overflow):
  - Increments on each accepted beat.
  - Clears on an accepted beat with EoD; that beat pops the FIFO.
  - oErrLen sets if EoD arrives at beat index != len, or if beat index exceeds len without EoD. The FIFO still pops only on EoD.
- FIFO empty:
  - oMAC_ReadyRsp = 1, so an orphan beat is dropped.
  - Both oX_ValidRsp are 0.
  - oErrOrphan sets if iMAC_ValidRsp=1.
- Push and pop in the same cycle (not full): occupancy unchanged.

## Timing
- Reset state:
  - oMAC_ValidRd = 0; oMAC_* fields = 0.
  - FIFO empty; oOutstanding = 0; beat counter = 0.
  - rr pointer = DM, so IF wins the first tie.
  - oErrOrphan = oErrLen = 0.
  - oX_ReadyRd = 0 while reset is high.
  - Response outputs follow the empty-FIFO rule.
- Request latency: accepted at edge k, visible on oMAC_* after edge k; 1 cycle.
- Back-to-back throughput is 1 request/cycle while iMAC_ReadyRd = 1 and the FIFO is not full.
- Response path: zero-cycle combinational pass-through. No response buffering.
- Reset mid-operation: FIFO, slot, counter, pointer and error flags are cleared. In-flight MAC responses afterwards are orphans.
- Valid/ready rule: request fields and ready from the upstream masters must stay stable until the handshake. The block does not drop an asserted oMAC_ValidRd until iMAC_ReadyRd.

## Test plan
- Single IF request (Addr 0x1000, Tag 3, Len 1, QoS 2); MAC returns 2 beats, EoD on 2nd -> oMAC_ValidRd 1 cycle after accept; both beats appear on oIF_*; oOutstanding 0→1→0; no error.
- IF QoS 5 and DM QoS 9 both valid -> DM granted first, IF next cycle; responses returned IF-order-agnostic MAC in order DM then IF route correctly.
- Equal QoS 4 from both masters for 4 consecutive requests -> grants alternate IF, DM, IF, DM.
- DEPTH=4: 4 requests accepted, MAC withholds responses -> 5th request sees oX_ReadyRd=0 and oOutstanding=4; after one EoD beat, grant resumes the next cycle.
- Len=3 request, MAC sends EoD on 2nd beat -> oErrLen=1, FIFO popped. MAC beat with FIFO empty -> oErrOrphan=1, oMAC_ReadyRsp=1, no oX_ValidRsp.
- Stall: iMAC_ReadyRd=0 for 3 cycles with slot full -> oMAC_* stable, oX_ReadyRd=0. Assert reset mid-burst -> all outputs return to reset values at the next edge.
